// File: rtl/spi_transmit.sv
// SPI slave transmitter: oversamples MCU-driven sck/ncs in the clk domain and
// shifts 12-bit pixel words out on sdo, MSB first, in 16-bit frames.
module spi_transmit #(
  parameter int unsigned frameBits  = 16,
  parameter int unsigned dataBits   = 12,
  parameter int unsigned syncStages = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sck,
  input  logic                ncs,
  output logic                sdo,
  input  logic [dataBits-1:0] readData,
  input  logic                readValid,
  output logic                readReady,
  output logic                busy,
  output logic                frameDone,
  output logic                frameAbort,
  output logic                underflow
);

  localparam int unsigned cntBits = $clog2(frameBits);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state, stateNext;
  logic [frameBits-1:0]    shiftReg, shiftNext;
  logic [cntBits-1:0]      cnt, cntNext;
  logic [dataBits-1:0]     holdData;
  logic                    holdFull;
  logic [syncStages-1:0]   sckSync, ncsSync;
  logic                    sckHist, ncsHist;
  logic                    sckS, ncsS;
  logic                    sckFall, ncsFall, ncsRise;
  logic                    load, accept;
  logic                    doneNext, abortNext, underNext;

  assign sckS    = sckSync[syncStages-1];
  assign ncsS    = ncsSync[syncStages-1];
  assign sckFall = sckHist & ~sckS;
  assign ncsFall = ncsHist & ~ncsS;
  assign ncsRise = ~ncsHist & ncsS;

  assign readReady = ~holdFull;
  assign accept    = readValid & ~holdFull;
  assign sdo       = shiftReg[frameBits-1];
  assign busy      = (state != IDLE);

  always_comb begin
    stateNext = state;
    shiftNext = shiftReg;
    cntNext   = cnt;
    load      = 1'b0;
    doneNext  = 1'b0;
    abortNext = 1'b0;
    underNext = 1'b0;
    case (state)
      IDLE: begin
        if (ncsFall) begin
          load      = 1'b1;
          stateNext = SHIFT;
        end
      end
      SHIFT: begin
        // ncs rising wins over a coincident sck fall
        if (ncsRise) begin
          abortNext = 1'b1;
          stateNext = IDLE;
          shiftNext = '0;
        end else if (sckFall) begin
          if (cnt == '0) begin
            doneNext  = 1'b1;
            stateNext = DONE;
          end else begin
            shiftNext = {shiftReg[frameBits-2:0], 1'b0};
            cntNext   = cnt - cntBits'(1);
          end
        end
      end
      DONE: begin
        if (!ncsS) begin
          load      = 1'b1;
          stateNext = SHIFT;
        end else begin
          stateNext = IDLE;
          shiftNext = '0;
        end
      end
      default: begin
        stateNext = IDLE;
        shiftNext = '0;
      end
    endcase
    if (load) begin
      shiftNext = holdFull ? {holdData, {(frameBits-dataBits){1'b0}}} : '0;
      cntNext   = cntBits'(frameBits - 1);
      underNext = ~holdFull;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shiftReg   <= '0;
      cnt        <= cntBits'(frameBits - 1);
      holdData   <= '0;
      holdFull   <= 1'b0;
      sckSync    <= '0;
      ncsSync    <= '1;
      sckHist    <= 1'b0;
      ncsHist    <= 1'b1;
      frameDone  <= 1'b0;
      frameAbort <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      state      <= stateNext;
      shiftReg   <= shiftNext;
      cnt        <= cntNext;
      sckSync    <= {sckSync[syncStages-2:0], sck};
      ncsSync    <= {ncsSync[syncStages-2:0], ncs};
      sckHist    <= sckS;
      ncsHist    <= ncsS;
      frameDone  <= doneNext;
      frameAbort <= abortNext;
      underflow  <= underNext;
      // accept only happens when empty, so a same-cycle load never drops it
      if (accept) begin
        holdData <= readData;
        holdFull <= 1'b1;
      end else if (load) begin
        holdFull <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_transmit.sv
// Bench for spi_transmit: an MCU model drives sck/ncs at clk/8 and captures
// sdo on sck falling edges; a word queue models the holding register.
`timescale 1ns/1ps
module tb_spi_transmit;

  logic        clk = 1'b0;
  logic        reset, sck, ncs, sdo;
  logic [11:0] readData;
  logic        readValid, readReady, busy, frameDone, frameAbort, underflow;

  int nAsserts = 0;
  int nFail    = 0;
  int doneCnt  = 0;
  int abortCnt = 0;
  int underCnt = 0;
  int d0, a0, u0, eu;
  logic [31:0] cap, expv;
  logic [11:0] rnd;
  logic [11:0] holdModel[$];

  spi_transmit #(.frameBits(16), .dataBits(12), .syncStages(2)) dut (
    .clk(clk), .reset(reset), .sck(sck), .ncs(ncs), .sdo(sdo),
    .readData(readData), .readValid(readValid), .readReady(readReady),
    .busy(busy), .frameDone(frameDone), .frameAbort(frameAbort),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frameDone)  doneCnt++;
    if (frameAbort) abortCnt++;
    if (underflow)  underCnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [11:0] v);
    bit ok = 0;
    @(negedge clk);
    readData  = v;
    readValid = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (readReady) begin ok = 1; break; end
      @(negedge clk);
    end
    if (ok) begin
      @(negedge clk);
      holdModel.push_back(v);
    end
    readValid = 1'b0;
    check("push_accept", 32'(ok), 1);
  endtask

  // frames: back-to-back frame count; abortAfter: raise ncs after that many falls (-1: none)
  task automatic mcu(input int frames, input int abortAfter,
                     output logic [31:0] capt, output logic [31:0] expd, output int expUnder);
    bit aborted = 0;
    capt = '0; expd = '0; expUnder = 0;
    @(negedge clk);
    ncs = 1'b0;
    ticks(6);
    check("ready_at_load", 32'(readReady), 1);
    check("busy_in_frame", 32'(busy), 1);
    for (int f = 0; f < frames && !aborted; f++) begin
      if (holdModel.size() > 0) expd = {expd[15:0], holdModel.pop_front(), 4'h0};
      else begin
        expd = {expd[15:0], 16'h0000};
        expUnder++;
      end
      for (int b = 0; b < 16; b++) begin
        if (b == abortAfter) begin aborted = 1; break; end
        sck = 1'b1;
        ticks(4);
        capt = {capt[30:0], sdo};
        sck = 1'b0;
        if (f == frames - 1 && b == 15) ticks(1);
        else ticks(4);
      end
    end
    ncs = 1'b1;
    ticks(8);
  endtask

  initial begin
    reset = 1'b1; sck = 1'b0; ncs = 1'b1; readValid = 1'b0; readData = '0;
    ticks(4);
    check("rst_sdo", 32'(sdo), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(readReady), 1);
    check("rst_done", 32'(frameDone), 0);
    check("rst_abort", 32'(frameAbort), 0);
    check("rst_under", 32'(underflow), 0);
    reset = 1'b0;
    ticks(4);

    // basic frame
    push(12'hABC);
    check("basic_full", 32'(readReady), 0);
    d0 = doneCnt; u0 = underCnt; a0 = abortCnt;
    mcu(1, -1, cap, expv, eu);
    check("basic_data", cap, expv);
    check("basic_const", cap, 32'h0000ABC0);
    check("basic_done", 32'(doneCnt - d0), 1);
    check("basic_under", 32'(underCnt - u0), 32'(eu));
    check("basic_abort", 32'(abortCnt - a0), 0);
    check("basic_sdo_idle", 32'(sdo), 0);
    check("basic_busy_idle", 32'(busy), 0);

    // underflow
    d0 = doneCnt; u0 = underCnt;
    mcu(1, -1, cap, expv, eu);
    check("under_data", cap, expv);
    check("under_pulse", 32'(underCnt - u0), 1);
    check("under_model", 32'(eu), 1);
    check("under_done", 32'(doneCnt - d0), 1);

    // back-to-back
    push(12'h123);
    d0 = doneCnt; u0 = underCnt;
    fork
      mcu(2, -1, cap, expv, eu);
      begin ticks(20); push(12'h456); end
    join
    check("b2b_data", cap, expv);
    check("b2b_const", cap, 32'h12304560);
    check("b2b_done", 32'(doneCnt - d0), 2);
    check("b2b_under", 32'(underCnt - u0), 0);

    // abort mid-frame
    push(12'hF0F);
    d0 = doneCnt; a0 = abortCnt;
    fork
      mcu(1, 5, cap, expv, eu);
      begin ticks(20); push(12'h00A); end
    join
    check("abort_pulse", 32'(abortCnt - a0), 1);
    check("abort_nodone", 32'(doneCnt - d0), 0);
    check("abort_sdo", 32'(sdo), 0);
    check("abort_busy", 32'(busy), 0);
    u0 = underCnt;
    mcu(1, -1, cap, expv, eu);
    check("after_abort_data", cap, expv);
    check("after_abort_const", cap, 32'h000000A0);
    check("after_abort_under", 32'(underCnt - u0), 0);

    // backpressure
    push(12'h111);
    @(negedge clk);
    readData  = 12'h777;
    readValid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ticks(1);
      check("bp_ready_low", 32'(readReady), 0);
    end
    readValid = 1'b0;
    mcu(1, -1, cap, expv, eu);
    check("bp_data", cap, expv);
    check("bp_const", cap, 32'h00001110);
    check("bp_ready_after", 32'(readReady), 1);

    // reset mid-frame with a word waiting in the holding register
    push(12'h5A5);
    @(negedge clk);
    ncs = 1'b0;
    ticks(6);
    holdModel.delete();
    push(12'h333);
    check("mid_ready_full", 32'(readReady), 0);
    for (int b = 0; b < 8; b++) begin
      sck = 1'b1; ticks(4);
      sck = 1'b0; ticks(4);
    end
    u0 = underCnt;
    reset = 1'b1;
    ncs   = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_sdo", 32'(sdo), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ready", 32'(readReady), 1);
    @(negedge clk);
    reset = 1'b0;
    holdModel.delete();
    ticks(8);
    d0 = doneCnt;
    mcu(1, -1, cap, expv, eu);
    check("post_rst_data", cap, 32'h0);
    check("post_rst_under", 32'(underCnt - u0), 1);
    check("post_rst_done", 32'(doneCnt - d0), 1);

    // randomized frames
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        rnd = 12'($urandom);
        push(rnd);
      end
      d0 = doneCnt; u0 = underCnt;
      mcu(1, -1, cap, expv, eu);
      check("rnd_data", cap, expv);
      check("rnd_under", 32'(underCnt - u0), 32'(eu));
      check("rnd_done", 32'(doneCnt - d0), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule

// File: doc/spi_transmit.md
Name: spi_transmit

Overview:
- SPI slave transmitter: the return path from the edge-detection accelerator to the MCU.
- Runs entirely in the FPGA system clock domain. Oversamples the MCU-driven sck and ncs, and shifts processed 12-bit pixel words out on sdo, MSB first.
- Uses 16-bit frames, with the pixel word in bits [15:4] and zeros in bits [3:0]. This matches the frame format the MCU already uses on the inbound link.
- Pixel words arrive from the output buffer over a valid/ready handshake into a one-word holding register.

Parameters:
- frameBits, 16, bits per SPI frame.
- dataBits, 12, payload width; placed in the frame MSBs, remaining low bits zero.
- syncStages, 2, synchronizer depth on sck and ncs.

Ports:
- clk  input  1  system clock; must be at least 8x the sck frequency.
- reset  input  1  synchronous, active-high reset.
- sck  input  1  SPI clock from MCU; idles low; asynchronous to clk.
- ncs  input  1  SPI chip select from MCU; active low; asynchronous to clk.
- sdo  output  1  serial data to MCU; 0 whenever no frame is active (tristate handled at top level).
- readData  input  dataBits  pixel word from output buffer.
- readValid  input  1  readData is valid.
- readReady  output  1  holding register empty; a word is accepted when readValid and readReady are both high.
- busy  output  1  frame in progress.
- frameDone  output  1  one-clk pulse after the last bit of a frame has been sampled.
- frameAbort  output  1  one-clk pulse when ncs deasserts mid-frame.
- underflow  output  1  one-clk pulse when a frame starts with the holding register empty.

Behaviour:
- Reset values:
  - sdo=0, busy=0, frameDone=0, frameAbort=0, underflow=0.
  - Holding register empty, so readReady=1.
  - Shift register 0, bit counter frameBits-1, state IDLE.
  - Synchronizers preset to idle levels: ncs=1, sck=0.
- Synchronization and edge detection:
  - sck and ncs each pass through syncStages flops, then one history flop for edge detection.
  - Detected events: ncsFall, ncsRise, sckFall.
- Latency: sdo is a registered output (shift MSB). A new value appears on sdo 3 clk after the pin edge is first sampled (2 sync stages + 1 register).
- Timing contract: the MCU samples sdo on sck falling edges. The block updates sdo after each detected sck falling edge. Hold is guaranteed by the sync latency; setup is guaranteed by the clk >= 8x sck requirement.
- Holding register:
  - Accepts a word on readValid & readReady.
  - Cleared at each frame load.
  - readReady = holding empty (combinational from the holding-full flag).
  - No bypass: a word accepted in the same cycle as a load is kept for the next frame.
- State machine: IDLE, SHIFT, DONE.
  - IDLE:
    - sdo=0, busy=0.
    - On ncsFall: load shift = {holding, zeros} (or all-zero if holding empty, and pulse underflow). Set bit counter to frameBits-1 and go to SHIFT.
  - SHIFT:
    - busy=1.
    - On sckFall: if counter==0, go to DONE and pulse frameDone; otherwise shift left by one and decrement the counter.
    - On ncsRise: pulse frameAbort, go to IDLE, sdo=0. Remaining bits are discarded, never resumed.
  - DONE (one clk):
    - If ncs is still low (synchronized): reload from holding exactly as in IDLE and return to SHIFT. This supports back-to-back frames with no gap.
    - Otherwise go to IDLE.
- Simultaneous events:
  - ncsRise takes priority over sckFall in the same cycle.
  - ncsFall and ncsRise cannot both occur in the same cycle.
  - Extra sck edges while in IDLE are ignored.
- Reset mid-frame: all state returns to the reset values on the next clk edge. The holding word is discarded.
- Counter arithmetic: width is $clog2(frameBits) bits, unsigned. It never wraps below 0, because the counter reaching 0 exits SHIFT.

Test Plan:
- Basic frame: reset, then push 0xABC; drop ncs and send 16 sck pulses at clk/sck=8. The MCU model captures 0xABC0 on falling edges, frameDone pulses once after the 16th falling edge, readReady returns to 1 at load, and sdo=0 after ncs rises.
- Underflow: no word pushed; run a 16-bit frame. The MCU captures 0x0000, underflow pulses once at load, and frameDone pulses once.
- Back-to-back: push 0x123; feed 0x456 during frame 1; hold ncs low for 32 sck. The MCU captures 0x1230 then 0x4560, frameDone pulses twice, and underflow never pulses.
- Abort: push 0xF0F and 0x00A; raise ncs after 5 falling edges. frameAbort pulses, frameDone does not, and sdo=0. The next frame returns 0x00A0, not the remainder of 0xF0F0.
- Backpressure: with the holding register full, assert readValid with 0x777. readReady stays 0 until the next load, and the word is not overwritten.
- Reset mid-frame: assert reset after 8 bits. On the next clk, sdo=0, busy=0, readReady=1 and the holding register is empty. A subsequent frame with no push returns 0x0000 with underflow.
